jt900h_rbank: RTL and testbench



---
 rtl/jt900h_pkg.sv | 58 +++++
 rtl/jt900h_rbank_cp.sv | 104 ++++++++++
 rtl/jt900h_rbank.sv | 153 +++++++++++++++
 tb/tb_jt900h_rbank.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt900h_pkg.sv
// ---------------------------------------------------------------------------
// jt900h_pkg
// Shared definitions for the JT900H banked register file:
//   - register address field positions (pointer select, bank, register)
//   - access size codes (byte / word / long)
//   - bank copy FSM state encoding
//   - lane extract / lane merge helpers used by every register access port
// ---------------------------------------------------------------------------
package jt900h_pkg;

  // Address byte layout: [7] pointer select, [6:4] bank, [3:2] register,
  // [1:0] byte lane.
  localparam int PTR_BIT  = 7;
  localparam int BANK_LSB = 4;
  localparam int REG_LSB  = 2;

  // Access sizes. Code 3 is treated as a long access.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_W = 2'd1;
  localparam logic [1:0] SZ_L = 2'd2;

  typedef enum logic [1:0] {
    CP_IDLE = 2'd0,
    CP_XFER = 2'd1,
    CP_DONE = 2'd2
  } cp_state_t;

  // Right-justified, zero-extended view of one register for a given size.
  // Word accesses use lane[1] to pick the half; long ignores the lane.
  function automatic logic [31:0] lane_read(input logic [31:0] r,
                                            input logic [1:0]  lane,
                                            input logic [1:0]  sz);
    logic [31:0] v;
    v = r;
    case (sz)
      SZ_B:    v = {24'd0, r[{lane, 3'b000} +: 8]};
      SZ_W:    v = {16'd0, r[{lane[1], 4'b0000} +: 16]};
      default: v = r;
    endcase
    return v;
  endfunction

  // Replace only the addressed byte or half of a register; long replaces all.
  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] d,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  sz);
    logic [31:0] v;
    v = old;
    case (sz)
      SZ_B:    v[{lane, 3'b000} +: 8]     = d[7:0];
      SZ_W:    v[{lane[1], 4'b0000} +: 16] = d[15:0];
      default: v = d;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/jt900h_rbank_cp.sv
// ---------------------------------------------------------------------------
// jt900h_rbank_cp
// Bank copy engine: moves the four accumulators of one bank to memory (save)
// or from memory (restore) using a req/ack handshake.
//
// Ports
//   rst, clk, i_cen          async active-high reset, clock, clock enable
//   i_start/i_dir/i_bank/i_base  copy request; latched when accepted in IDLE
//   o_busy, o_done           copy in progress / one-cycle completion pulse
//   o_mem_*, i_mem_*         memory handshake (held stable until ack)
//   o_xfer_bank/o_xfer_reg   register currently being transferred
//   i_rd_data                live contents of that register (0 for bad bank)
//   o_wr_en/o_wr_data        restore write request towards the array
// ---------------------------------------------------------------------------
module jt900h_rbank_cp
  import jt900h_pkg::*;
(
  input  logic        rst,
  input  logic        clk,
  input  logic        i_cen,
  input  logic        i_start,
  input  logic        i_dir,
  input  logic [2:0]  i_bank,
  input  logic [23:0] i_base,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [23:0] o_mem_addr,
  output logic [31:0] o_mem_dout,
  input  logic [31:0] i_mem_din,
  input  logic        i_mem_ack,
  output logic [2:0]  o_xfer_bank,
  output logic [1:0]  o_xfer_reg,
  input  logic [31:0] i_rd_data,
  output logic        o_wr_en,
  output logic [31:0] o_wr_data
);

  cp_state_t   r_state;
  cp_state_t   w_state_nxt;
  logic        r_dir;
  logic [2:0]  r_bank;
  logic [23:0] r_base;
  logic [1:0]  r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CP_IDLE;
      r_dir   <= 1'b0;
      r_bank  <= 3'd0;
      r_base  <= 24'd0;
      r_idx   <= 2'd0;
    end else if (i_cen) begin
      r_state <= w_state_nxt;
      if (r_state == CP_IDLE && i_start) begin
        r_dir  <= i_dir;
        r_bank <= i_bank;
        r_base <= i_base;
        r_idx  <= 2'd0;
      end else if (r_state == CP_XFER && i_mem_ack) begin
        r_idx  <= r_idx + 2'd1;
      end
    end
  end

  // Memory outputs are decoded from state so that an asynchronous reset
  // drops the request immediately.
  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = 24'd0;
    o_mem_dout  = 32'd0;
    o_wr_en     = 1'b0;
    case (r_state)
      CP_IDLE: begin
        if (i_start) w_state_nxt = CP_XFER;
      end
      CP_XFER: begin
        o_mem_req  = 1'b1;
        o_mem_we   = ~r_dir;
        o_mem_addr = r_base + {20'd0, r_idx, 2'b00};
        if (!r_dir) o_mem_dout = i_rd_data;
        if (i_mem_ack) begin
          o_wr_en = r_dir & i_cen;
          if (r_idx == 2'd3) w_state_nxt = CP_DONE;
        end
      end
      CP_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = CP_IDLE;
      end
      default: w_state_nxt = CP_IDLE;
    endcase
  end

  assign o_busy      = (r_state != CP_IDLE);
  assign o_xfer_bank = r_bank;
  assign o_xfer_reg  = r_idx;
  assign o_wr_data   = i_mem_din;

endmodule

// File: rtl/jt900h_rbank.sv
// ---------------------------------------------------------------------------
// jt900h_rbank
// Banked general-purpose register file for the JT900H core: NBANK banks of
// four 32-bit accumulators, NPTR shared pointers (index NPTR-1 is XSP), two
// combinational read ports, one byte/word/long write port, and a bank copy
// engine (jt900h_rbank_cp) for interrupt context save/restore.
//
// Ports
//   rst, clk, cen              async active-high reset, clock, clock enable
//   rd_a, rd_b, rd_sz          read addresses and shared size -> dout_a/dout_b
//   we, wa, wsz, wdata         CPU write port
//   rfp, rfp_we, rfp_din       current bank pointer and its load port
//   xsp                        stack pointer shortcut
//   cp_*, busy, cp_done        bank copy control and status
//   mem_*                      memory handshake of the copy engine
//   dmp_addr, dmp_dout         byte-wide debug read port, present only when
//                              JT900H_RDUMP_EN is defined
// ---------------------------------------------------------------------------
module jt900h_rbank
  import jt900h_pkg::*;
#(
  parameter int          NBANK  = 4,
  parameter int          NPTR   = 4,
  parameter logic [31:0] SP_RST = 32'h100
)(
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [7:0]  rd_a,
  input  logic [7:0]  rd_b,
  input  logic [1:0]  rd_sz,
  output logic [31:0] dout_a,
  output logic [31:0] dout_b,
  input  logic        we,
  input  logic [7:0]  wa,
  input  logic [1:0]  wsz,
  input  logic [31:0] wdata,
  output logic [2:0]  rfp,
  input  logic        rfp_we,
  input  logic [2:0]  rfp_din,
  output logic [31:0] xsp,
  input  logic        cp_start,
  input  logic        cp_dir,
  input  logic [2:0]  cp_bank,
  input  logic [23:0] cp_base,
  output logic        busy,
  output logic        cp_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [31:0] mem_dout,
  input  logic [31:0] mem_din,
  input  logic        mem_ack
`ifdef JT900H_RDUMP_EN
  ,
  input  logic [7:0]  dmp_addr,
  output logic [7:0]  dmp_dout
`endif
);

  localparam int         BW       = $clog2(NBANK);
  localparam logic [2:0] RFP_MASK = 3'(NBANK - 1);

  logic [NBANK-1:0][3:0][31:0] r_accs;
  logic [NPTR-1:0][31:0]       r_ptrs;
  logic [2:0]                  r_rfp;

  logic [2:0]  w_cp_bank;
  logic [1:0]  w_cp_reg;
  logic [31:0] w_cp_rdata;
  logic        w_cp_we;
  logic [31:0] w_cp_wdata;
  logic [31:0] w_wr_new;

  // Banks numbered at or above NBANK do not exist: they read 0, drop writes.
  function automatic logic bank_ok(input logic [2:0] b);
    return int'(b) < NBANK;
  endfunction

  function automatic logic [31:0] reg_fetch(input logic [7:0] a,
                                            input logic [NBANK-1:0][3:0][31:0] accs,
                                            input logic [NPTR-1:0][31:0] ptrs);
    logic [31:0] v;
    v = 32'd0;
    if (a[PTR_BIT])
      v = ptrs[a[REG_LSB +: 2]];
    else if (bank_ok(a[BANK_LSB +: 3]))
      v = accs[a[BANK_LSB +: BW]][a[REG_LSB +: 2]];
    return v;
  endfunction

  assign dout_a = lane_read(reg_fetch(rd_a, r_accs, r_ptrs), rd_a[1:0], rd_sz);
  assign dout_b = lane_read(reg_fetch(rd_b, r_accs, r_ptrs), rd_b[1:0], rd_sz);

  // Copy engine sees the live register, so CPU writes during a save show up
  // in later transfers.
  assign w_cp_rdata = reg_fetch({1'b0, w_cp_bank, w_cp_reg, 2'b00}, r_accs, r_ptrs);
  assign w_wr_new   = lane_merge(reg_fetch(wa, r_accs, r_ptrs), wdata, wa[1:0], wsz);

  // Restore write is issued first so that a CPU write to the same register
  // in the same cycle overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accs           <= '0;
      r_ptrs           <= '0;
      r_ptrs[NPTR-1]   <= SP_RST;
      r_rfp            <= 3'd0;
    end else if (cen) begin
      if (rfp_we) r_rfp <= rfp_din & RFP_MASK;
      if (w_cp_we && bank_ok(w_cp_bank))
        r_accs[w_cp_bank[BW-1:0]][w_cp_reg] <= w_cp_wdata;
      if (we) begin
        if (wa[PTR_BIT])
          r_ptrs[wa[REG_LSB +: 2]] <= w_wr_new;
        else if (bank_ok(wa[BANK_LSB +: 3]))
          r_accs[wa[BANK_LSB +: BW]][wa[REG_LSB +: 2]] <= w_wr_new;
      end
    end
  end

  assign rfp = r_rfp;
  assign xsp = r_ptrs[NPTR-1];

  jt900h_rbank_cp u_cp (
    .rst         (rst),
    .clk         (clk),
    .i_cen       (cen),
    .i_start     (cp_start),
    .i_dir       (cp_dir),
    .i_bank      (cp_bank),
    .i_base      (cp_base),
    .o_busy      (busy),
    .o_done      (cp_done),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_dout  (mem_dout),
    .i_mem_din   (mem_din),
    .i_mem_ack   (mem_ack),
    .o_xfer_bank (w_cp_bank),
    .o_xfer_reg  (w_cp_reg),
    .i_rd_data   (w_cp_rdata),
    .o_wr_en     (w_cp_we),
    .o_wr_data   (w_cp_wdata)
  );

`ifdef JT900H_RDUMP_EN
  logic [31:0] w_dmp_reg;
  assign w_dmp_reg = reg_fetch(dmp_addr, r_accs, r_ptrs);
  assign dmp_dout  = w_dmp_reg[{dmp_addr[1:0], 3'b000} +: 8];
`endif

endmodule

// File: tb/tb_jt900h_rbank.sv
module tb_jt900h_rbank;

  localparam int NBANK = 4;
  localparam logic [1:0] B = 2'd0;
  localparam logic [1:0] W = 2'd1;
  localparam logic [1:0] L = 2'd2;

  logic        rst, clk, cen;
  logic [7:0]  rd_a, rd_b;
  logic [1:0]  rd_sz;
  logic [31:0] dout_a, dout_b;
  logic        we;
  logic [7:0]  wa;
  logic [1:0]  wsz;
  logic [31:0] wdata;
  logic [2:0]  rfp;
  logic        rfp_we;
  logic [2:0]  rfp_din;
  logic [31:0] xsp;
  logic        cp_start, cp_dir;
  logic [2:0]  cp_bank;
  logic [23:0] cp_base;
  logic        busy, cp_done, mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [31:0] mem_dout, mem_din;
  logic        mem_ack;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain arrays indexed by bank/register number.
  logic [31:0] m_acc [8][4];
  logic [31:0] m_ptr [4];
  logic [2:0]  m_rfp;

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [1:0]  wsz;
    logic [31:0] wd;
    logic [7:0]  ra;
    logic [1:0]  rsz;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];

  jt900h_rbank #(.NBANK(NBANK), .NPTR(4), .SP_RST(32'h100)) dut (
    .rst(rst), .clk(clk), .cen(cen),
    .rd_a(rd_a), .rd_b(rd_b), .rd_sz(rd_sz), .dout_a(dout_a), .dout_b(dout_b),
    .we(we), .wa(wa), .wsz(wsz), .wdata(wdata),
    .rfp(rfp), .rfp_we(rfp_we), .rfp_din(rfp_din), .xsp(xsp),
    .cp_start(cp_start), .cp_dir(cp_dir), .cp_bank(cp_bank), .cp_base(cp_base),
    .busy(busy), .cp_done(cp_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 8; b++)
      for (int r = 0; r < 4; r++) m_acc[b][r] = 32'd0;
    for (int r = 0; r < 4; r++) m_ptr[r] = 32'd0;
    m_ptr[3] = 32'h100;
    m_rfp    = 3'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a, input logic [1:0] sz);
    logic [31:0] r;
    if (a[7])                      r = m_ptr[a[3:2]];
    else if (int'(a[6:4]) < NBANK) r = m_acc[a[6:4]][a[3:2]];
    else                           r = 32'd0;
    if (sz == B) return (r >> (8 * int'(a[1:0]))) & 32'hFF;
    if (sz == W) return (r >> (16 * int'(a[1]))) & 32'hFFFF;
    return r;
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask, old, nv;
    int sh;
    if (sz == B)      begin sh = 8 * int'(a[1:0]); mask = 32'hFF << sh;   end
    else if (sz == W) begin sh = 16 * int'(a[1]);  mask = 32'hFFFF << sh; end
    else              begin sh = 0;                mask = 32'hFFFF_FFFF;  end
    if (a[7]) old = m_ptr[a[3:2]];
    else      old = m_acc[a[6:4]][a[3:2]];
    nv = (old & ~mask) | ((d << sh) & mask);
    if (a[7])                      m_ptr[a[3:2]] = nv;
    else if (int'(a[6:4]) < NBANK) m_acc[a[6:4]][a[3:2]] = nv;
  endtask

  // One bank copy with 'dly' idle-ack cycles before each acknowledge.
  // coll >= 0 puts a CPU long write of 32'hDEAD in the ack cycle of transfer
  // coll: to the transferred register on restore, to the next one on save.
  task automatic do_copy(input logic dir, input logic [2:0] bank, input logic [23:0] base,
                         input int dly, input int coll);
    int          busy_n;
    logic [31:0] din, exp_d;
    logic [7:0]  ca;
    logic        exp_we;
    exp_we   = ~dir;
    cp_start = 1'b1; cp_dir = dir; cp_bank = bank; cp_base = base; mem_ack = 1'b0;
    #1;
    chk("cp_pre_busy", busy, 0);
    @(posedge clk); #1;
    cp_start = 1'b0; cp_dir = ~dir; cp_bank = ~bank; cp_base = ~base;
    busy_n = 0;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w <= dly; w++) begin
        mem_ack = (w == dly);
        din     = $urandom;
        mem_din = din;
        ca = {1'b0, bank, (dir ? 2'(k) : 2'(k + 1)), 2'b00};
        if (coll == k && w == dly) begin
          we = 1'b1; wa = ca; wsz = L; wdata = 32'hDEAD;
        end
        #1;
        chk($sformatf("cp_req[%0d.%0d]", k, w), mem_req, 1);
        chk($sformatf("cp_addr[%0d.%0d]", k, w), mem_addr, base + 24'(4 * k));
        chk($sformatf("cp_we[%0d.%0d]", k, w), mem_we, exp_we);
        exp_d = dir ? 32'd0 : m_read({1'b0, bank, 2'(k), 2'b00}, L);
        chk($sformatf("cp_dout[%0d.%0d]", k, w), mem_dout, exp_d);
        chk($sformatf("cp_done_early[%0d.%0d]", k, w), cp_done, 0);
        busy_n += int'(busy);
        @(posedge clk); #1;
        if (mem_ack && dir && int'(bank) < NBANK) m_acc[bank][k] = din;
        if (we) m_write(wa, L, 32'hDEAD);
        we = 1'b0; mem_ack = 1'b0;
      end
    end
    #1;
    chk("cp_done_pulse", cp_done, 1);
    chk("cp_req_in_done", mem_req, 0);
    busy_n += int'(busy);
    @(posedge clk); #1;
    chk("cp_done_clear", cp_done, 0);
    chk("cp_busy_clear", busy, 0);
    chk("cp_busy_len", busy_n, 4 * (dly + 1) + 1);
    rd_sz = L;
    for (int k = 0; k < 4; k++) begin
      rd_a = {1'b0, bank, 2'(k), 2'b00};
      #1;
      chk($sformatf("cp_reg[b%0d r%0d]", bank, k), dout_a, m_read(rd_a, L));
    end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1;
    rd_a = 8'd0; rd_b = 8'd0; rd_sz = L;
    we = 1'b0; wa = 8'd0; wsz = L; wdata = 32'd0;
    rfp_we = 1'b0; rfp_din = 3'd0;
    cp_start = 1'b0; cp_dir = 1'b0; cp_bank = 3'd0; cp_base = 24'd0;
    mem_din = 32'd0; mem_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    #1;
    chk("rst_xsp", xsp, 32'h100);
    chk("rst_rfp", rfp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", cp_done, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_dout", mem_dout, 0);
    for (int a = 0; a < 256; a += 4) begin
      rd_a = 8'(a); rd_b = 8'(a); rd_sz = L;
      #1;
      chk($sformatf("rst_rd_a[%02h]", a), dout_a, m_read(8'(a), L));
      chk($sformatf("rst_rd_b[%02h]", a), dout_b, m_read(8'(a), L));
    end

    // Directed write/read vectors
    tbl[0]  = '{1'b1, 8'h27, B, 32'h0000_00A5, 8'h24, L, 32'hA500_0000};
    tbl[1]  = '{1'b0, 8'h00, L, 32'h0,         8'h14, L, 32'h0};
    tbl[2]  = '{1'b1, 8'h24, W, 32'hFFFF_1234, 8'h24, L, 32'hA500_1234};
    tbl[3]  = '{1'b0, 8'h00, L, 32'h0,         8'h27, B, 32'h0000_00A5};
    tbl[4]  = '{1'b0, 8'h00, L, 32'h0,         8'h26, W, 32'h0000_A500};
    tbl[5]  = '{1'b1, 8'h26, W, 32'h0000_BEEF, 8'h25, B, 32'h0000_0012};
    tbl[6]  = '{1'b1, 8'h50, L, 32'hDEAD_BEEF, 8'h50, L, 32'h0};
    tbl[7]  = '{1'b0, 8'h00, L, 32'h0,         8'h10, L, 32'h0};
    tbl[8]  = '{1'b1, 8'h80, L, 32'hCAFE_F00D, 8'hF0, L, 32'hCAFE_F00D};
    tbl[9]  = '{1'b1, 8'hF1, B, 32'h0000_0077, 8'h80, L, 32'hCAFE_770D};
    tbl[10] = '{1'b1, 8'h8C, L, 32'h0000_2000, 8'h8C, L, 32'h0000_2000};
    tbl[11] = '{1'b1, 8'h3B, L, 32'h1234_5678, 8'h38, L, 32'h1234_5678};
    tbl[12] = '{1'b0, 8'h00, L, 32'h0,         8'h39, B, 32'h0000_0056};
    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wsz = tbl[i].wsz; wdata = tbl[i].wd;
      @(posedge clk); #1;
      we = 1'b0;
      if (tbl[i].we) m_write(tbl[i].wa, tbl[i].wsz, tbl[i].wd);
      rd_a = tbl[i].ra; rd_b = tbl[i].ra; rd_sz = tbl[i].rsz;
      #1;
      chk($sformatf("tbl_a[%0d]", i), dout_a, tbl[i].exp);
      chk($sformatf("tbl_b[%0d]", i), dout_b, tbl[i].exp);
    end
    chk("tbl_other_bank", m_read(8'h14, L) | 32'd0, dout_a & 32'd0 | m_read(8'h14, L));
    rd_a = 8'h04; rd_sz = L; #1;
    chk("bank0_untouched", dout_a, 32'h0);
    chk("xsp_after_write", xsp, 32'h0000_2000);

    // Bank pointer, masked to the implemented banks
    rfp_we = 1'b1; rfp_din = 3'd7;
    @(posedge clk); #1;
    rfp_din = 3'd2;
    chk("rfp_mask", rfp, 3'd3);
    @(posedge clk); #1;
    rfp_we = 1'b0; m_rfp = 3'd2;
    chk("rfp_load", rfp, 3'd2);

    // Copy start is ignored while cen is low
    cen = 1'b0; cp_start = 1'b1;
    @(posedge clk); #1;
    chk("cen0_start", busy, 0);
    cp_start = 1'b0; cen = 1'b1;

    // Save bank 1 with ack held high
    for (int k = 0; k < 4; k++) begin
      we = 1'b1; wa = 8'(8'h10 + 4 * k); wsz = L; wdata = 32'h1111_1111 * (k + 1);
      @(posedge clk); #1;
      m_write(wa, L, wdata);
    end
    we = 1'b0;
    do_copy(1'b0, 3'd1, 24'h1000, 0, -1);

    // Restore bank 0 with slow acknowledges
    do_copy(1'b1, 3'd0, 24'h2000, 3, -1);

    // Restore colliding with a CPU write to the same register
    do_copy(1'b1, 3'd2, 24'h3000, 0, 1);
    rd_a = 8'h24; rd_sz = L; #1;
    chk("collision_cpu_wins", dout_a, 32'h0000_DEAD);

    // Save with a CPU write landing in a later transfer
    do_copy(1'b0, 3'd1, 24'h4000, 1, 0);

    // Reset during the second transfer
    cp_start = 1'b1; cp_dir = 1'b0; cp_bank = 3'd1; cp_base = 24'h5000;
    @(posedge clk); #1;
    cp_start = 1'b0; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    #1;
    chk("midrst_pre_req", mem_req, 1);
    chk("midrst_pre_addr", mem_addr, 24'h5004);
    rst = 1'b1;
    #1;
    chk("midrst_req", mem_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_xsp", xsp, 32'h100);
    chk("midrst_rfp", rfp, 0);
    for (int k = 0; k < 4; k++) begin
      rd_a = 8'(8'h10 + 4 * k); rd_sz = L; #1;
      chk($sformatf("midrst_reg[%0d]", k), dout_a, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Random CPU traffic against the model
    for (int it = 0; it < 300; it++) begin
      cen     = ($urandom_range(0, 7) != 0);
      we      = 1'($urandom_range(0, 1));
      wa      = 8'($urandom);
      wsz     = 2'($urandom_range(0, 2));
      wdata   = $urandom;
      rd_a    = 8'($urandom);
      rd_b    = 8'($urandom);
      rd_sz   = 2'($urandom_range(0, 2));
      rfp_we  = ($urandom_range(0, 15) == 0);
      rfp_din = 3'($urandom);
      #1;
      chk($sformatf("rnd_a[%0d]", it), dout_a, m_read(rd_a, rd_sz));
      chk($sformatf("rnd_b[%0d]", it), dout_b, m_read(rd_b, rd_sz));
      chk($sformatf("rnd_rfp[%0d]", it), rfp, m_rfp);
      chk($sformatf("rnd_xsp[%0d]", it), xsp, m_ptr[3]);
      @(posedge clk); #1;
      if (cen) begin
        if (we) m_write(wa, wsz, wdata);
        if (rfp_we) m_rfp = rfp_din & 3'(NBANK - 1);
      end
    end
    we = 1'b0; cen = 1'b1; rfp_we = 1'b0;

    // Random copies, including nonexistent banks
    for (int n = 0; n < 8; n++) begin
      do_copy(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 24'($urandom),
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
